// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotate-and-find-first picker: scans valid_i from last_i+1, wrapping
// modulo NUM_REQ, and reports the first set bit.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  // Walk the ring once starting just after the last winner; first hit wins.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_i) + k) % NUM_REQ;
      if (!any_o && valid_i[idx]) begin
        any_o    = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request/response channel pair
// between NUM_REQ requesters, with one outstanding transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int REQ_WIDTH = 64,
  parameter  int RSP_WIDTH = 32,
  localparam int IDX_W     = idx_w(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*REQ_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [RSP_WIDTH-1:0]         rsp_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [REQ_WIDTH-1:0]         mem_req_data,
  input  logic                         mem_rsp_valid,
  output logic                         mem_rsp_ready,
  input  logic [RSP_WIDTH-1:0]         mem_rsp_data,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  mem_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid_i  (req_valid),
    .last_i   (rr_q),
    .winner_o (pick_idx),
    .any_o    (pick_any)
  );

  // State, grant and rotation pointer; reset leaves requester 0 first in line.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Next state: grant in IDLE, forward in REQ, return response in RESP.
  // The rotation pointer only moves when a response completes.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_valid && mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rsp_valid && mem_rsp_ready) begin
          rr_d    = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake steering toward the granted requester; everything idle
  // outside its own phase, so an early memory response is held off in REQ.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    mem_req_data  = req_data[int'(grant_q)*REQ_WIDTH +: REQ_WIDTH];
    case (state_q)
      REQ: begin
        mem_req_valid      = req_valid[grant_q];
        req_ready[grant_q] = mem_req_ready;
      end
      RESP: begin
        rsp_valid[grant_q] = mem_rsp_valid;
        mem_rsp_ready      = rsp_ready[grant_q];
      end
      default: ;
    endcase
  end

  assign rsp_data = mem_rsp_data;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with three requesters.
module tb_mem_port_arbiter;

  localparam int NR = 3;
  localparam int RW = 64;
  localparam int SW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*RW-1:0]  req_data;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [SW-1:0]     rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [RW-1:0]     mem_req_data;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [SW-1:0]     mem_rsp_data;
  logic [1:0]        grant_id;
  logic              busy;

  mem_port_arbiter #(
    .NUM_REQ   (NR),
    .REQ_WIDTH (RW),
    .RSP_WIDTH (SW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_data  (mem_req_data),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_data  (mem_rsp_data),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [63:0] data;
  } exp_t;

  exp_t exp_req_q[$];
  exp_t exp_rsp_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},      64'(busy),          64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready),     64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid),     64'd0);
    chk({tag, "_mreq_vld"},  64'(mem_req_valid), 64'd0);
    chk({tag, "_mrsp_rdy"},  64'(mem_rsp_ready), 64'd0);
    chk({tag, "_grant_id"},  64'(grant_id),      64'd0);
  endtask

  // Wait for the downstream request handshake and score it; returns just
  // after the firing edge.
  task automatic expect_req_fire(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!(mem_req_valid && mem_req_ready) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_fire"}, 64'(mem_req_valid && mem_req_ready), 64'd1);
    if (exp_req_q.size() > 0) e = exp_req_q.pop_front();
    else e = '{idx: -1, data: '1};
    chk({tag, "_gnt"},  64'(grant_id),  64'(e.idx));
    chk({tag, "_data"}, mem_req_data,   e.data);
    chk({tag, "_rdy"},  64'(req_ready), 64'(oh(e.idx)));
    tick();
  endtask

  // Wait for the downstream response handshake, score the routed response,
  // then confirm the arbiter is back in IDLE.
  task automatic expect_rsp_fire(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!(mem_rsp_valid && mem_rsp_ready) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_rfire"}, 64'(mem_rsp_valid && mem_rsp_ready), 64'd1);
    if (exp_rsp_q.size() > 0) e = exp_rsp_q.pop_front();
    else e = '{idx: -1, data: '1};
    chk({tag, "_rvld"},  64'(rsp_valid), 64'(oh(e.idx)));
    chk({tag, "_rdata"}, 64'(rsp_data),  e.data);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req_valid     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pay [2][2];
    req_data     = '0;
    rsp_ready    = '1;
    mem_rsp_data = '0;

    // Reset state
    do_reset();
    @(negedge clock);
    check_quiet("rst");
    tick();

    // Single requester, zero-wait memory
    req_valid            = 3'b001;
    req_data[0*RW +: RW] = 64'h0000_1111_2222_3333;
    mem_req_ready        = 1'b1;
    exp_req_q.push_back('{idx: 0, data: 64'h0000_1111_2222_3333});
    expect_req_fire("single");
    req_valid     = 3'b000;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    exp_rsp_q.push_back('{idx: 0, data: 64'hCAFE_F00D});
    expect_rsp_fire("single");

    // Contention: requesters 0 and 1 held valid from a fresh rotation
    do_reset();
    mem_req_ready = 1'b1;
    pay[0][0] = 64'hA0A0_0000_0000_0000;
    pay[0][1] = 64'hA1A1_0000_0000_0001;
    pay[1][0] = 64'hB0B0_0000_0000_0010;
    pay[1][1] = 64'hB1B1_0000_0000_0011;
    req_data[0*RW +: RW] = pay[0][0];
    req_data[1*RW +: RW] = pay[1][0];
    req_valid            = 3'b011;
    for (int k = 0; k < 4; k++) exp_req_q.push_back('{idx: k % 2, data: pay[k%2][k/2]});
    for (int k = 0; k < 4; k++) begin
      int r;
      r = k % 2;
      expect_req_fire($sformatf("cont%0d", k));
      if (k < 2) req_data[r*RW +: RW] = pay[r][1];
      else req_valid[r] = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1000 + k;
      exp_rsp_q.push_back('{idx: r, data: 64'(32'h1000 + k)});
      expect_rsp_fire($sformatf("cont%0d", k));
    end

    // Backpressure on both the request and the response side
    req_valid            = 3'b100;
    req_data[2*RW +: RW] = 64'hC0DE_C0DE_0000_0002;
    mem_req_ready        = 1'b0;
    exp_req_q.push_back('{idx: 2, data: 64'hC0DE_C0DE_0000_0002});
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("bp_vld%0d", i),  64'(mem_req_valid), 64'd1);
      chk($sformatf("bp_rdy%0d", i),  64'(req_ready),     64'd0);
      chk($sformatf("bp_data%0d", i), mem_req_data,       64'hC0DE_C0DE_0000_0002);
      tick();
    end
    mem_req_ready = 1'b1;
    expect_req_fire("bp");
    req_valid     = 3'b000;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0BAD_BEEF;
    rsp_ready     = 3'b011;
    exp_rsp_q.push_back('{idx: 2, data: 64'h0BAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("bp_mrsp_rdy%0d", i), 64'(mem_rsp_ready), 64'd0);
      chk($sformatf("bp_rsp_vld%0d", i),  64'(rsp_valid),     64'(oh(2)));
      tick();
    end
    rsp_ready = 3'b111;
    expect_rsp_fire("bp");

    // Wrap from rr=2 with requesters 0 and 2, plus an early response
    req_valid            = 3'b101;
    req_data[0*RW +: RW] = 64'hE000_0000_0000_00E0;
    req_data[2*RW +: RW] = 64'hF000_0000_0000_00F2;
    mem_req_ready        = 1'b0;
    mem_rsp_valid        = 1'b1;
    mem_rsp_data         = 32'h6666_0000;
    exp_req_q.push_back('{idx: 0, data: 64'hE000_0000_0000_00E0});
    exp_req_q.push_back('{idx: 2, data: 64'hF000_0000_0000_00F2});
    tick();
    @(negedge clock);
    chk("early_gnt",      64'(grant_id),      64'd0);
    chk("early_mrsp_rdy", 64'(mem_rsp_ready), 64'd0);
    chk("early_rsp_vld",  64'(rsp_valid),     64'd0);
    tick();
    mem_req_ready = 1'b1;
    exp_rsp_q.push_back('{idx: 0, data: 64'h6666_0000});
    expect_req_fire("wrap0");
    req_valid[0] = 1'b0;
    expect_rsp_fire("wrap0");
    expect_req_fire("wrap2");
    req_valid[2]  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h7777_0002;
    exp_rsp_q.push_back('{idx: 2, data: 64'h7777_0002});
    expect_rsp_fire("wrap2");

    // Reset while waiting in RESP abandons the transaction
    req_valid            = 3'b010;
    req_data[1*RW +: RW] = 64'h1111_0000_0000_0001;
    exp_req_q.push_back('{idx: 1, data: 64'h1111_0000_0000_0001});
    expect_req_fire("rr_pre");
    req_valid = 3'b000;
    @(negedge clock);
    chk("rr_resp_busy", 64'(busy), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5A5A_5A5A;
    @(negedge clock);
    check_quiet("rr_after");
    tick();
    req_valid            = 3'b011;
    req_data[0*RW +: RW] = 64'h0000_0000_0000_0A00;
    req_data[1*RW +: RW] = 64'h0000_0000_0000_0B01;
    exp_req_q.push_back('{idx: 0, data: 64'h0000_0000_0000_0A00});
    exp_rsp_q.push_back('{idx: 0, data: 64'h5A5A_5A5A});
    expect_req_fire("rr_post");
    req_valid = 3'b000;
    expect_rsp_fire("rr_post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
